// File: rtl/lif_injector.sv
// lif_injector: edge transmitter for the LIF cell grid.
// It accepts one data word over a valid/ready handshake and sends it as
// single-cycle pulses on one lane of the 4-bit neighbour bus. Each frame has
// a start pulse, then WIDTH data slots sent MSB first, then an idle guard.
module lif_injector #(
    parameter int WIDTH = 8,
    parameter int LANE  = 2,
    parameter int SLOT  = 2,
    parameter int GAP   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic [3:0]       bus_out,
    output logic             busy,
    output logic [7:0]       frames
);

    // The counters keep at least one bit when a parameter collapses to a
    // single value, so every compare below keeps a fixed, legal width.
    localparam int SW = (SLOT  > 1) ? $clog2(SLOT)  : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP   > 1) ? $clog2(GAP)   : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    // Refuse to build with parameter values the frame logic cannot handle.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("lif_injector: WIDTH must be in 1..32");
        end
        if (LANE < 0 || LANE > 3) begin : g_bad_lane
            $error("lif_injector: LANE must be in 0..3");
        end
        if (SLOT < 1) begin : g_bad_slot
            $error("lif_injector: SLOT must be at least 1");
        end
        if (GAP < 0) begin : g_bad_gap
            $error("lif_injector: GAP must not be negative");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        GUARD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shiftNext;
    logic [SW-1:0]    slotCnt_q, slotCnt_d;
    logic [BW-1:0]    bitCnt_q, bitCnt_d;
    logic [GW-1:0]    gapCnt_q, gapCnt_d;
    logic             pulse_d;
    logic [3:0]       busOut_q, busOut_d;
    logic             busy_q, busy_d;
    logic [7:0]       frames_q, frames_d;

    assign shiftNext = shift_q << 1;

    // Next-state logic. pulse_d is the lane value for the coming cycle. It can
    // only be 1 when the coming cycle is cycle 0 of a slot whose bit is 1, so
    // the pulse appears one cycle after the edge that decided it.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        slotCnt_d = slotCnt_q;
        bitCnt_d  = bitCnt_q;
        gapCnt_d  = gapCnt_q;
        frames_d  = frames_q;
        pulse_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d   = START;
                    shift_d   = data_in;
                    slotCnt_d = '0;
                    bitCnt_d  = '0;
                    pulse_d   = 1'b1;
                end
            end
            START: begin
                if (slotCnt_q == SLOT_LAST) begin
                    state_d   = DATA;
                    slotCnt_d = '0;
                    bitCnt_d  = '0;
                    pulse_d   = shift_q[WIDTH-1];
                end else begin
                    slotCnt_d = slotCnt_q + SW'(1);
                end
            end
            DATA: begin
                if (slotCnt_q == SLOT_LAST) begin
                    slotCnt_d = '0;
                    shift_d   = shiftNext;
                    if (bitCnt_q == BIT_LAST) begin
                        if (GAP == 0) begin
                            state_d  = IDLE;
                            frames_d = frames_q + 8'd1;
                        end else begin
                            state_d  = GUARD;
                            gapCnt_d = '0;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + BW'(1);
                        pulse_d  = shiftNext[WIDTH-1];
                    end
                end else begin
                    slotCnt_d = slotCnt_q + SW'(1);
                end
            end
            GUARD: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d  = IDLE;
                    frames_d = frames_q + 8'd1;
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busOut_d       = 4'b0000;
        busOut_d[LANE] = pulse_d;
        busy_d         = (state_d != IDLE);
    end

    // State and output registers. A reset drops any frame in flight without
    // counting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            slotCnt_q <= '0;
            bitCnt_q  <= '0;
            gapCnt_q  <= '0;
            busOut_q  <= 4'b0000;
            busy_q    <= 1'b0;
            frames_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            slotCnt_q <= slotCnt_d;
            bitCnt_q  <= bitCnt_d;
            gapCnt_q  <= gapCnt_d;
            busOut_q  <= busOut_d;
            busy_q    <= busy_d;
            frames_q  <= frames_d;
        end
    end

    assign ready   = (state_q == IDLE) && !reset;
    assign bus_out = busOut_q;
    assign busy    = busy_q;
    assign frames  = frames_q;

endmodule

// File: tb/tb_lif_injector.sv
// Testbench for lif_injector. It uses the default instance plus a second
// instance with LANE=0, SLOT=1, GAP=0. Expected per-cycle waveforms are
// pushed to a queue when a frame is started and popped one cycle at a time.
module tb_lif_injector;

    logic       clk;
    logic       reset;
    logic [7:0] dataIn;
    logic       valid;
    logic       ready;
    logic [3:0] busOut;
    logic       busy;
    logic [7:0] frames;

    logic [7:0] dataIn2;
    logic       valid2;
    logic       ready2;
    logic [3:0] busOut2;
    logic       busy2;
    logic [7:0] frames2;

    int asserts  = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] bus;
        logic       busy;
        logic       rdy;
    } exp_t;

    exp_t expQ[$];

    lif_injector dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (dataIn),
        .valid   (valid),
        .ready   (ready),
        .bus_out (busOut),
        .busy    (busy),
        .frames  (frames)
    );

    lif_injector #(.WIDTH(8), .LANE(0), .SLOT(1), .GAP(0)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .data_in (dataIn2),
        .valid   (valid2),
        .ready   (ready2),
        .bus_out (busOut2),
        .busy    (busy2),
        .frames  (frames2)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame model: (w+1)*s+g busy cycles. A pulse appears in cycle 0
    // of the start slot and in cycle 0 of each data slot whose bit is 1.
    function automatic void pushFrame(input logic [7:0] d, input int lane,
                                      input int w, input int s, input int g);
        int   len;
        int   sl;
        exp_t e;
        len = (w + 1) * s + g;
        for (int c = 0; c < len; c++) begin
            sl     = c / s;
            e.bus  = 4'b0000;
            e.busy = 1'b1;
            e.rdy  = 1'b0;
            if ((c % s) == 0 && sl <= w) begin
                if (sl == 0) e.bus[lane] = 1'b1;
                else if (d[w - sl]) e.bus[lane] = 1'b1;
            end
            expQ.push_back(e);
        end
    endfunction

    function automatic void pushIdle();
        exp_t e;
        e.bus  = 4'b0000;
        e.busy = 1'b0;
        e.rdy  = 1'b1;
        expQ.push_back(e);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b0;
        valid2 = 1'b0;
        repeat (2) @(negedge clk);
        asserts++;
        if ({busOut, busy, frames, ready} !== {4'b0000, 1'b0, 8'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state bus/busy/frames/ready got %b/%b/%0d/%b want 0000/0/0/0",
                     busOut, busy, frames, ready);
        end
        reset = 1'b0;
        #1;
        asserts++;
        if (ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready got %b want 1", ready);
        end
    endtask

    task automatic test_frames();
        logic [7:0] pats [3];
        int         c;
        exp_t       e;
        pats[0] = 8'hA5;
        pats[1] = 8'h00;
        pats[2] = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            valid  = 1'b1;
            dataIn = pats[p];
            pushFrame(pats[p], 2, 8, 2, 4);
            pushIdle();
            @(posedge clk);
            #1;
            valid  = 1'b0;
            dataIn = 8'($urandom);
            c = 0;
            while (expQ.size() > 0) begin
                @(negedge clk);
                e = expQ.pop_front();
                asserts++;
                if ({busOut, busy, ready} !== {e.bus, e.busy, e.rdy}) begin
                    failures++;
                    $display("[TB] FAIL frame_%h c=%0d bus/busy/ready got %b/%b/%b want %b/%b/%b",
                             pats[p], c, busOut, busy, ready, e.bus, e.busy, e.rdy);
                end
                c++;
            end
            asserts++;
            if (frames !== 8'(p + 1)) begin
                failures++;
                $display("[TB] FAIL frame_count_%h got %0d want %0d", pats[p], frames, p + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   firstReady;
        exp_t e;
        firstReady = -1;
        @(negedge clk);
        valid  = 1'b1;
        dataIn = 8'hFF;
        pushFrame(8'hFF, 2, 8, 2, 4);
        pushIdle();
        pushFrame(8'h01, 2, 8, 2, 4);
        pushIdle();
        @(posedge clk);
        #1;
        dataIn = 8'h01;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            e = expQ.pop_front();
            asserts++;
            if ({busOut, busy, ready} !== {e.bus, e.busy, e.rdy}) begin
                failures++;
                $display("[TB] FAIL b2b c=%0d bus/busy/ready got %b/%b/%b want %b/%b/%b",
                         c, busOut, busy, ready, e.bus, e.busy, e.rdy);
            end
            if (ready === 1'b1 && firstReady < 0) firstReady = c;
            valid = (c < 4 || (c >= 8 && c <= 22) || c == 30) ? 1'b1 : 1'b0;
            if (c == 24) dataIn = 8'h5A;
        end
        asserts++;
        if (firstReady != 22) begin
            failures++;
            $display("[TB] FAIL b2b_second_accept cycle got %0d want 22", firstReady);
        end
        asserts++;
        if (frames !== 8'd5) begin
            failures++;
            $display("[TB] FAIL b2b_frame_count got %0d want 5", frames);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        @(negedge clk);
        valid  = 1'b1;
        dataIn = 8'hA5;
        pushFrame(8'hA5, 2, 8, 2, 4);
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e = expQ.pop_front();
            asserts++;
            if ({busOut, busy} !== {e.bus, e.busy}) begin
                failures++;
                $display("[TB] FAIL abort_pre c=%0d bus/busy got %b/%b want %b/%b",
                         c, busOut, busy, e.bus, e.busy);
            end
        end
        reset = 1'b1;
        expQ.delete();
        @(negedge clk);
        asserts++;
        if ({busOut, busy, frames, ready} !== {4'b0000, 1'b0, 8'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL abort_state bus/busy/frames/ready got %b/%b/%0d/%b want 0000/0/0/0",
                     busOut, busy, frames, ready);
        end
        reset  = 1'b0;
        valid  = 1'b1;
        dataIn = 8'h3C;
        #1;
        asserts++;
        if (ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_ready_after got %b want 1", ready);
        end
        pushFrame(8'h3C, 2, 8, 2, 4);
        pushIdle();
        @(posedge clk);
        #1;
        valid = 1'b0;
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            asserts++;
            if ({busOut, busy, ready} !== {e.bus, e.busy, e.rdy}) begin
                failures++;
                $display("[TB] FAIL abort_new_frame bus/busy/ready got %b/%b/%b want %b/%b/%b",
                         busOut, busy, ready, e.bus, e.busy, e.rdy);
            end
        end
        asserts++;
        if (frames !== 8'd1) begin
            failures++;
            $display("[TB] FAIL abort_frame_count got %0d want 1", frames);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        valid  = 1'b1;
        dataIn = 8'($urandom);
        for (int j = 0; j < 23 * 256; j++) begin
            @(negedge clk);
            dataIn = 8'($urandom);
            if (j == 23 * 255 - 1) begin
                asserts++;
                if (frames !== 8'd255) begin
                    failures++;
                    $display("[TB] FAIL wrap_255 got %0d want 255", frames);
                end
            end
            if (j == 23 * 256 - 1) begin
                asserts++;
                if ({frames, ready} !== {8'd0, 1'b1}) begin
                    failures++;
                    $display("[TB] FAIL wrap_256 frames/ready got %0d/%b want 0/1", frames, ready);
                end
            end
        end
        for (int j = 0; j < 23; j++) begin
            @(negedge clk);
            if (j == 0) valid = 1'b0;
        end
        asserts++;
        if ({frames, ready} !== {8'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL wrap_257 frames/ready got %0d/%b want 1/1", frames, ready);
        end
    endtask

    task automatic test_lane0();
        int   c;
        exp_t e;
        @(negedge clk);
        valid2  = 1'b1;
        dataIn2 = 8'h80;
        pushFrame(8'h80, 0, 8, 1, 0);
        pushIdle();
        @(posedge clk);
        #1;
        valid2  = 1'b0;
        dataIn2 = 8'hFF;
        c = 0;
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            asserts++;
            if ({busOut2, busy2, ready2} !== {e.bus, e.busy, e.rdy}) begin
                failures++;
                $display("[TB] FAIL lane0 c=%0d bus/busy/ready got %b/%b/%b want %b/%b/%b",
                         c, busOut2, busy2, ready2, e.bus, e.busy, e.rdy);
            end
            c++;
        end
        asserts++;
        if (frames2 !== 8'd1) begin
            failures++;
            $display("[TB] FAIL lane0_frame_count got %0d want 1", frames2);
        end
    endtask

    // Test sequence.
    initial begin
        reset   = 1'b1;
        valid   = 1'b0;
        dataIn  = 8'h00;
        valid2  = 1'b0;
        dataIn2 = 8'h00;
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_midframe();
        test_wrap();
        test_lane0();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
